// File: rtl/video_timing_gen_1936x1088.sv
// rtl/video_timing_gen_1936x1088.sv - 1936x1088 sensor-side hs/vs/de timing source with coordinates
// Optional colour-bar pattern on o_rgb when VTG_TEST_PATTERN_EN is defined.
module video_timing_gen_1936x1088 #(
  parameter int H_BACK  = 40,
  parameter int H_DISP  = 1936,
  parameter int H_FRONT = 28,
  parameter int H_SYNC  = 44,
  parameter int V_BACK  = 18,
  parameter int V_DISP  = 1088,
  parameter int V_FRONT = 3,
  parameter int V_SYNC  = 5
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_frame_start,
  output logic [23:0] o_rgb
);

  localparam logic [11:0] C_HT         = 12'(H_BACK + H_DISP + H_FRONT);
  localparam logic [11:0] C_LINE_LAST  = 12'(H_BACK + H_DISP + H_FRONT + H_SYNC - 1);
  localparam logic [11:0] C_VT         = 12'(V_BACK + V_DISP + V_FRONT);
  localparam logic [11:0] C_FRAME_LAST = 12'(V_BACK + V_DISP + V_FRONT + V_SYNC - 1);
  localparam logic [11:0] C_H_DE0      = 12'(H_BACK);
  localparam logic [11:0] C_H_DE1      = 12'(H_BACK + H_DISP);
  localparam logic [11:0] C_V_DE0      = 12'(V_BACK);
  localparam logic [11:0] C_V_DE1      = 12'(V_BACK + V_DISP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      r_state;
  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic        r_frame_start;

  logic        w_hs_next;
  logic        w_vs_next;
  logic        w_de_next;
  logic [11:0] w_x_next;
  logic [11:0] w_y_next;
  logic        w_fs_next;

  assign w_hs_next = (r_h_cnt < C_HT);
  assign w_vs_next = (r_v_cnt < C_VT);
  assign w_de_next = (r_h_cnt >= C_H_DE0) && (r_h_cnt < C_H_DE1) &&
                     (r_v_cnt >= C_V_DE0) && (r_v_cnt < C_V_DE1);
  assign w_x_next  = w_de_next ? (r_h_cnt - C_H_DE0) : 12'd0;
  assign w_y_next  = w_de_next ? (r_v_cnt - C_V_DE0) : 12'd0;
  assign w_fs_next = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);

  // Dropping i_en abandons the frame on the same edge; outputs read 0 the next cycle.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_h_cnt       <= 12'd0;
      r_v_cnt       <= 12'd0;
      r_hs          <= 1'b0;
      r_vs          <= 1'b0;
      r_de          <= 1'b0;
      r_x           <= 12'd0;
      r_y           <= 12'd0;
      r_frame_start <= 1'b0;
    end else if (!i_en) begin
      r_state       <= IDLE;
      r_h_cnt       <= 12'd0;
      r_v_cnt       <= 12'd0;
      r_hs          <= 1'b0;
      r_vs          <= 1'b0;
      r_de          <= 1'b0;
      r_x           <= 12'd0;
      r_y           <= 12'd0;
      r_frame_start <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state       <= RUN;
          r_h_cnt       <= 12'd0;
          r_v_cnt       <= 12'd0;
          r_hs          <= 1'b0;
          r_vs          <= 1'b0;
          r_de          <= 1'b0;
          r_x           <= 12'd0;
          r_y           <= 12'd0;
          r_frame_start <= 1'b0;
        end
        RUN: begin
          r_hs          <= w_hs_next;
          r_vs          <= w_vs_next;
          r_de          <= w_de_next;
          r_x           <= w_x_next;
          r_y           <= w_y_next;
          r_frame_start <= w_fs_next;
          if (r_h_cnt == C_LINE_LAST) begin
            r_h_cnt <= 12'd0;
            r_v_cnt <= (r_v_cnt == C_FRAME_LAST) ? 12'd0 : r_v_cnt + 12'd1;
          end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_hs          = r_hs;
  assign o_vs          = r_vs;
  assign o_de          = r_de;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_frame_start = r_frame_start;

`ifdef VTG_TEST_PATTERN_EN
  localparam int          BAR_W = H_DISP / 8;
  localparam logic [11:0] C_B1  = 12'(1 * BAR_W);
  localparam logic [11:0] C_B2  = 12'(2 * BAR_W);
  localparam logic [11:0] C_B3  = 12'(3 * BAR_W);
  localparam logic [11:0] C_B4  = 12'(4 * BAR_W);
  localparam logic [11:0] C_B5  = 12'(5 * BAR_W);
  localparam logic [11:0] C_B6  = 12'(6 * BAR_W);
  localparam logic [11:0] C_B7  = 12'(7 * BAR_W);

  logic [23:0] r_rgb;
  logic [23:0] w_rgb_next;

  // Bar index via comparison against fixed edges rather than dividing o_x.
  always_comb begin
    w_rgb_next = 24'h000000;
    if (w_de_next) begin
      if      (w_x_next < C_B1) w_rgb_next = 24'hFFFFFF;
      else if (w_x_next < C_B2) w_rgb_next = 24'hFFFF00;
      else if (w_x_next < C_B3) w_rgb_next = 24'h00FFFF;
      else if (w_x_next < C_B4) w_rgb_next = 24'h00FF00;
      else if (w_x_next < C_B5) w_rgb_next = 24'hFF00FF;
      else if (w_x_next < C_B6) w_rgb_next = 24'hFF0000;
      else if (w_x_next < C_B7) w_rgb_next = 24'h0000FF;
      else                      w_rgb_next = 24'h000000;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= 24'h0;
    end else if (i_en && (r_state == RUN)) begin
      r_rgb <= w_rgb_next;
    end else begin
      r_rgb <= 24'h0;
    end
  end

  assign o_rgb = r_rgb;
`else
  assign o_rgb = 24'h0;
`endif

endmodule

// File: tb/tb_video_timing_gen_1936x1088.sv
// tb/tb_video_timing_gen_1936x1088.sv - scoreboard bench for video_timing_gen_1936x1088 at reduced geometry
module tb_video_timing_gen_1936x1088;

  localparam int HB = 4, HD = 16, HF = 3, HS = 5;
  localparam int VB = 2, VD = 4, VF = 1, VS = 2;
  localparam int LINE  = 28;
  localparam int FRAME = 9;
  localparam int FCLK  = 252;

  logic        clk;
  logic        rst_n;
  logic        i_en;
  logic        o_hs, o_vs, o_de, o_frame_start;
  logic [11:0] o_x, o_y;
  logic [23:0] o_rgb;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [51:0] exp_q[$];

  video_timing_gen_1936x1088 #(
    .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS),
    .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS)
  ) dut (
    .pixel_clk    (clk),
    .rst_n        (rst_n),
    .i_en         (i_en),
    .o_hs         (o_hs),
    .o_vs         (o_vs),
    .o_de         (o_de),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_frame_start(o_frame_start),
    .o_rgb        (o_rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [51:0] expected_at(input int t);
    int h, v;
    logic hs, vs, de, fs;
    logic [11:0] x, y;
    logic [23:0] rgb;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    h  = t % LINE;
    v  = (t / LINE) % FRAME;
    hs = (h < HB + HD + HF);
    vs = (v < VB + VD + VF);
    de = (h >= HB) && (h < HB + HD) && (v >= VB) && (v < VB + VD);
    fs = ((t % FCLK) == 0);
    x  = de ? 12'(h - HB) : 12'd0;
    y  = de ? 12'(v - VB) : 12'd0;
    rgb = 24'h0;
`ifdef VTG_TEST_PATTERN_EN
    if (de) rgb = bars[int'(x) / (HD / 8)];
`endif
    return {hs, vs, de, fs, x, y, rgb};
  endfunction

  // Reference model: pushes the output expected after each clock edge.
  bit m_run = 0;
  int m_t   = 0;
  always @(posedge clk) begin
    cyc++;
    if (!rst_n || !i_en) begin
      m_run = 0;
      exp_q.push_back('0);
    end else if (!m_run) begin
      m_run = 1;
      m_t   = 0;
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(expected_at(m_t));
      m_t++;
    end
  end

  // Monitor: compares every cycle away from the active edge.
  always @(negedge clk) begin
    logic [51:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_n) e = '0;
      chk("cycle_outputs", 64'({o_hs, o_vs, o_de, o_frame_start, o_x, o_y, o_rgb}), 64'(e));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fs(input string name, input int c0);
    bit seen = 0;
    for (int i = 0; i < 2 * FCLK && !seen; i++) begin
      @(negedge clk);
      #1;
      if (o_frame_start) seen = 1;
    end
    chk({name, "_seen"}, 64'(seen), 64'd1);
    if (seen) chk({name, "_latency"}, 64'(cyc - c0), 64'd2);
  endtask

  // Called at the cycle where o_frame_start is high; measures exactly one frame.
  task automatic count_frame(input string name);
    int hs_hi = 0, vs_hi = 0, de_n = 0, fs_n = 0;
    int de_first = -1, de_last = -1;
    logic [11:0] fx = 0, fy = 0, lx = 0, ly = 0;
    for (int i = 0; i < FCLK; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      hs_hi += int'(o_hs);
      vs_hi += int'(o_vs);
      fs_n  += int'(o_frame_start);
      if (o_de) begin
        de_n++;
        if (de_first < 0) begin de_first = i; fx = o_x; fy = o_y; end
        de_last = i; lx = o_x; ly = o_y;
      end
    end
    chk({name, "_hs_high"}, 64'(hs_hi), 64'(23 * 9));
    chk({name, "_hs_low"},  64'(FCLK - hs_hi), 64'(5 * 9));
    chk({name, "_vs_high"}, 64'(vs_hi), 64'(196));
    chk({name, "_vs_low"},  64'(FCLK - vs_hi), 64'(56));
    chk({name, "_de_count"}, 64'(de_n), 64'(64));
    chk({name, "_fs_count"}, 64'(fs_n), 64'(1));
    chk({name, "_de_first_idx"}, 64'(de_first), 64'(60));
    chk({name, "_de_first_xy"}, 64'({fx, fy}), 64'({12'd0, 12'd0}));
    chk({name, "_de_last_idx"}, 64'(de_last), 64'(159));
    chk({name, "_de_last_xy"}, 64'({lx, ly}), 64'({12'd15, 12'd3}));
    @(negedge clk);
    #1;
    chk({name, "_wrap_fs"}, 64'({o_frame_start, o_hs, o_vs}), 64'(3'b111));
  endtask

  initial begin
    int c0;
    bit hit;
    rst_n = 1'b0;
    i_en  = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 64'({o_hs, o_vs, o_de, o_frame_start, o_x, o_y, o_rgb}), 64'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_outputs", 64'({o_hs, o_vs, o_de, o_frame_start, o_x, o_y, o_rgb}), 64'd0);

    c0 = cyc;
    i_en = 1'b1;
    wait_fs("start", c0);
    count_frame("frame1");

    // Drop enable mid-frame at roughly h=10, v=5, hold off for 10 clocks.
    hit = 0;
    for (int i = 0; i < 2 * FCLK && !hit; i++) begin
      @(negedge clk);
      if (o_de && o_x == 12'd6 && o_y == 12'd3) hit = 1;
    end
    chk("drop_point_found", 64'(hit), 64'd1);
    tick();
    i_en = 1'b0;
    tick();
    chk("drop_outputs_zero", 64'({o_hs, o_vs, o_de, o_frame_start, o_x, o_y, o_rgb}), 64'd0);
    repeat (9) tick();
    c0 = cyc;
    i_en = 1'b1;
    wait_fs("restart", c0);
    count_frame("frame2");

    // Asynchronous reset in the middle of an active line.
    hit = 0;
    for (int i = 0; i < 2 * FCLK && !hit; i++) begin
      @(negedge clk);
      if (o_de && o_x == 12'd5) hit = 1;
    end
    chk("reset_point_found", 64'(hit), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_zero", 64'({o_hs, o_vs, o_de, o_frame_start, o_x, o_y, o_rgb}), 64'd0);
    repeat (3) tick();
    c0 = cyc;
    rst_n = 1'b1;
    wait_fs("post_reset", c0);
    count_frame("frame3");

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen_1936x1088.md
# video_timing_gen_1936x1088

Generates the raw 1936x1088 sensor-side video timing (hs/vs/de) that the HDMI path's 1936→1920 cropper consumes. It is the transmitter end of that timing interface and the reference source for bring-up without a camera. It also provides pixel coordinates, a frame-start pulse and an optional colour-bar pattern. It sits in the pixel_clk domain, feeding the cropper and any frame-buffer reader.

## Interface
Parameters:
- H_BACK, 40, back porch in clocks (hs high, de low, start of line)
- H_DISP, 1936, active pixels per line
- H_FRONT, 28, front porch in clocks
- H_SYNC, 44, hs-low clocks at end of line
- V_BACK, 18, back-porch lines
- V_DISP, 1088, active lines
- V_FRONT, 3, front-porch lines
- V_SYNC, 5, vs-low lines at end of frame

Ports:
- pixel_clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  run enable; low forces idle
- o_hs  out  1  line timing: high for back+active+front, low for sync
- o_vs  out  1  frame timing: high for back+active+front lines, low for sync lines
- o_de  out  1  active pixel
- o_x  out  12  pixel column during o_de, else 0
- o_y  out  12  pixel row during o_de, else 0
- o_frame_start  out  1  one-cycle pulse at the first cycle of each frame
- o_rgb  out  24  test pattern {R,G,B}; see Configuration

## Operation
- Derived totals: HT = H_BACK+H_DISP+H_FRONT (2004), LINE = HT+H_SYNC (2048), VT = V_BACK+V_DISP+V_FRONT (1109), FRAME = VT+V_SYNC (1114).
- h_cnt, 12-bit, 0..LINE-1, wraps to 0. v_cnt, 12-bit, 0..FRAME-1, increments when h_cnt wraps and wraps to 0 after FRAME-1.
- hs_next = (h_cnt < HT).
- vs_next = (v_cnt < VT).
- de_next = h_cnt in [H_BACK, H_BACK+H_DISP) AND v_cnt in [V_BACK, V_BACK+V_DISP).
- x = h_cnt−H_BACK and y = v_cnt−V_BACK when de_next is set, else 0.
- Resulting hs/vs relationship:
  - A line starts at the hs rising edge.
  - vs rises together with hs at h_cnt=0, v_cnt=0.
  - The first hs falling edge of a frame ends line 0.
  - A downstream counter that clears on vs low, counts hs-high clocks and counts hs falling edges therefore sees h index == h_cnt and line index == v_cnt.
- frame_start_next = (h_cnt==0 && v_cnt==0 && run).
- States:
  - IDLE: counters held at 0, all outputs 0.
  - RUN: counters advance.
  - Transition IDLE→RUN on i_en=1, sampled at the clock edge. The counters start at 0 that same edge, so the first RUN cycle is frame start.
  - Transition RUN→IDLE on i_en=0 at any point, mid-line or mid-frame. Counters clear immediately and the partial frame is abandoned.
  - Re-enabling always starts a fresh frame at h_cnt=0, v_cnt=0.
- Asynchronous reset mid-frame: all outputs and counters go to 0 immediately; the block returns to IDLE.

## Timing
- All outputs are registered, with latency 1 clock from counter state to output.
- Reset value of every output is 0: o_hs, o_vs, o_de, o_x, o_y, o_frame_start, o_rgb.
- First o_hs/o_vs/o_frame_start high is the 2nd clock after the first edge with i_en=1.
- Per line: o_hs high 2004 clocks, low 44. o_de high 1936 consecutive clocks, starting 40 clocks after o_hs rises.
- Per frame: o_vs high 1109 lines (2,271,232 clocks), low 5 lines (10,240 clocks). Frame period is 2,281,472 clocks.
- o_de lines are v_cnt 18..1105; 1088 lines per frame.
- o_x, o_y and o_rgb are aligned with o_de on the same cycle.
- Wrap boundaries:
  - At h_cnt=LINE-1 → 0 and v_cnt=FRAME-1 → 0 on the same edge, o_frame_start pulses and o_vs rises with o_hs.
  - No glitch or extra cycle at the wrap.

## Configuration
- VTG_TEST_PATTERN_EN defined:
  - o_rgb outputs 8 vertical bars of 242 pixels each, bar = o_x/242.
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - o_rgb is 0 outside o_de.
  - Division is done by comparison against constant bar edges, not a divider.
- Not defined: o_rgb is tied to 24'h0 and no pattern logic is synthesised. All other outputs are unchanged.

## Test plan
- Reset, then i_en=1 for 1 frame → o_frame_start pulses once at clock 2. Counting then gives o_hs high 2004, low 44 per line; o_vs high 2,271,232, low 10,240; o_de count 1936×1088 = 2,106,368.
- Check line 18 → o_de rises 40 clocks after o_hs rises with o_x=0, o_y=0. Last active pixel has o_x=1935, o_y=1087. o_de stays 0 on lines 0–17 and 1106–1113.
- Feed the outputs into the 1936→1920 cropper → cropper de count is 1920×1080 per frame, first active line is 22, first active column is 48.
- Drop i_en at h_cnt=500, v_cnt=300 for 10 clocks, then raise it → outputs are 0 the clock after the drop. On restart, o_frame_start fires 2 clocks after i_en rises and a full 1114-line frame follows.
- Assert rst_n low mid-active-line → all outputs are 0 asynchronously. After release with i_en=1, timing restarts from frame start.
- With VTG_TEST_PATTERN_EN: o_x=241 gives FFFFFF, o_x=242 gives FFFF00, o_x=1935 gives 000000, and o_rgb=0 while o_de=0. Without the macro, o_rgb is 0 throughout.
